rob_commit: RTL and testbench
=============================

Name: rob_commit

Overview:
- In-order retirement buffer: the back end of the issue-stage register-read path.
- Allocates instruction ids at rename.
- Accepts functional-unit (FU) results, then writes the physical register file (PRF) and sets the scoreboard bit, so waiting consumers at issue become ready.
- Retires in program order, writing the architectural register file (ARF).
- Sits between the FUs/rename and the PRF/scoreboard/ARF write ports of the issue stage.

Parameters:
- ROBSIZE, 16, number of entries; power of two; id width ID_BITS = $clog2(ROBSIZE).
- XLEN, 64, data width (taken from package C).
- PREG_ID_BITS / AREG_ID_BITS, from package C, physical/architectural register index widths.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous flush; empties the buffer
- alloc_valid_i  in  1  rename requests an entry
- alloc_ready_o  out  1  entry available
- alloc_rd_i  in  AREG_ID_BITS  architectural destination
- alloc_rd_valid_i  in  1  instruction writes rd
- alloc_prd_i  in  PREG_ID_BITS  physical destination
- alloc_id_o  out  ID_BITS  id assigned (tail pointer)
- wb_valid_i  in  1  FU result valid
- wb_ready_o  out  1  result accepted (tied 1 while not flushing)
- wb_id_i  in  ID_BITS  result id
- wb_data_i  in  XLEN  result value
- prf_we_o / prf_waddr_o / prf_wdata_o  out  1 / PREG_ID_BITS / XLEN  PRF write port
- sb_we_o / sb_waddr_o / sb_wdata_o  out  2 / 2xPREG_ID_BITS / 2x1  scoreboard ports; [0]=set on writeback, [1]=clear on alloc
- arf_we_o / arf_waddr_o / arf_wdata_o  out  1 / AREG_ID_BITS / XLEN  ARF commit port
- commit_valid_o / commit_id_o  out  1 / ID_BITS  retirement notification
- empty_o  out  1  no live entries

Behaviour:
- Reset (async, rstn low): head=tail=0, count=0, all entry valid/done bits 0; every output write-enable, commit_valid_o and alloc/wb data outputs 0; empty_o=1, alloc_ready_o=1.
- State: circular buffer with head/tail pointers (ID_BITS wide, wrap modulo ROBSIZE) and count (ID_BITS+1 wide).
  - Entry fields: valid, done, rd, rd_valid, prd, data.
- Allocation:
  - alloc_ready_o = (count != ROBSIZE) && !flush_i.
  - On alloc_valid_i && alloc_ready_o: write the entry at tail (valid=1, done=0), tail++.
  - In the same cycle, combinationally drive sb_we_o[1] = alloc_rd_valid_i, addr = alloc_prd_i, data 0.
  - alloc_id_o = tail, combinational.
  - Full is evaluated before commit: no allocation when count==ROBSIZE even if a commit occurs in the same cycle.
- Writeback:
  - On wb_valid_i && wb_ready_o: entry[wb_id_i].data <= wb_data_i, done <= 1.
  - Next cycle (1-cycle latency, registered): prf_we_o=1, prf_waddr_o=entry prd, prf_wdata_o=data; sb_we_o[0]=1, sb_wdata_o[0]=1.
  - Writeback to an entry with valid=0 or done=1 is dropped with no PRF/scoreboard write; simulation assertion fires.
- Commit:
  - Combinational from head; one per cycle. If count!=0 && entry[head].done: commit_valid_o=1, commit_id_o=head.
  - ARF write: arf_we_o = rd_valid && rd!=0, waddr=rd, wdata=data.
  - At the clock edge: entry valid<=0, head++.
  - A result written this cycle is not committable until the next cycle (done is registered).
- count update: count += alloc_fire − commit_fire. Simultaneous alloc and commit leave count unchanged.
- Wrap: pointers roll ROBSIZE-1 -> 0 with no bubble.
- flush_i (synchronous):
  - At the edge: head=tail=0, count=0, all valid/done cleared.
  - During the flush cycle: alloc_ready_o=0, wb_ready_o=0, commit and ARF writes suppressed.
  - The registered PRF write pending from the previous cycle still completes.
- Reset mid-operation: all in-flight entries and any pending PRF write are discarded immediately.

Decomposition:
- Package C gains:
  - ROBSIZE and ID_BITS constants
  - rob_entry_t (valid, done, rd, rd_valid, prd, data)
  - wb_t (id, data) shared with FU outputs
- One natural sub-module: rob_ptr, a wrapping pointer/counter with inc enable and clear. Instantiated twice (head, tail).

Test Plan:
1. Reset, then alloc 3 entries (rd=5/6/7, prd=10/11/12) -> alloc_id_o 0,1,2; sb_we_o[1] pulses for prd 10,11,12; empty_o=0.
2. Writeback id1=0xAA before id0 -> PRF write prd11=0xAA next cycle, no commit. Writeback id0=0x55 -> commits id0 (ARF x5=0x55) then id1 (x6=0xAA) on consecutive cycles.
3. Fill 16 entries -> alloc_ready_o=0. Commit head while alloc_valid_i=1 -> no alloc that cycle; alloc accepted next cycle with id 0 (wrap).
4. Entry with rd=0, rd_valid=1 -> PRF written, commit_valid_o=1, arf_we_o=0.
5. flush_i with 4 live entries, one result pending -> pending PRF write completes, no ARF writes, empty_o=1, next alloc_id_o=0.
6. rstn low mid-stream (async, between edges) -> all outputs 0 immediately, alloc_ready_o=1, empty_o=1; writeback to a stale id afterwards is ignored.

Source files
------------

// File: rtl/rob_commit_pkg.sv
// Shared types and constants for the in-order retirement buffer and the
// functional units that report results into it.
package rob_commit_pkg;

    localparam int XLEN         = 64;
    localparam int PREG_ID_BITS = 6;
    localparam int AREG_ID_BITS = 5;
    localparam int ROBSIZE      = 16;
    localparam int ID_BITS      = $clog2(ROBSIZE);

    typedef logic [ID_BITS-1:0]      rob_id_t;
    typedef logic [PREG_ID_BITS-1:0] preg_t;
    typedef logic [AREG_ID_BITS-1:0] areg_t;
    typedef logic [XLEN-1:0]         xdata_t;

    // One buffer slot as seen by rename, writeback and commit.
    typedef struct packed {
        logic    valid;
        logic    done;
        areg_t   rd;
        logic    rd_valid;
        preg_t   prd;
        xdata_t  data;
    } rob_entry_t;

    // Result bundle produced by a functional unit.
    typedef struct packed {
        rob_id_t id;
        xdata_t  data;
    } wb_t;

    // x0 is hard-wired zero, so retiring into it never touches the ARF.
    function automatic logic arf_writes(input logic rd_valid, input areg_t rd);
        return rd_valid && (rd != '0);
    endfunction

endpackage

// File: rtl/rob_ptr.sv
// Wrapping pointer with increment enable and synchronous clear. The pointer
// is a power-of-two width so it rolls over to zero without extra logic.
module rob_ptr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_reg;

    // Pointer register: clear wins over increment.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_reg <= '0;
        end else if (clr) begin
            ptr_reg <= '0;
        end else if (inc) begin
            ptr_reg <= ptr_reg + W'(1);
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/rob_commit.sv
// In-order retirement buffer. Rename allocates ids at the tail, functional
// units deliver results by id (forwarded to the PRF and scoreboard one cycle
// later), and the head retires in program order into the ARF.
module rob_commit
    import rob_commit_pkg::*;
(
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         flush_i,
    // rename / allocation
    input  logic                         alloc_valid_i,
    output logic                         alloc_ready_o,
    input  logic [AREG_ID_BITS-1:0]      alloc_rd_i,
    input  logic                         alloc_rd_valid_i,
    input  logic [PREG_ID_BITS-1:0]      alloc_prd_i,
    output logic [ID_BITS-1:0]           alloc_id_o,
    // functional-unit writeback
    input  logic                         wb_valid_i,
    output logic                         wb_ready_o,
    input  logic [ID_BITS-1:0]           wb_id_i,
    input  logic [XLEN-1:0]              wb_data_i,
    // physical register file write port
    output logic                         prf_we_o,
    output logic [PREG_ID_BITS-1:0]      prf_waddr_o,
    output logic [XLEN-1:0]              prf_wdata_o,
    // scoreboard ports: [0] sets on writeback, [1] clears on allocation
    output logic [1:0]                   sb_we_o,
    output logic [1:0][PREG_ID_BITS-1:0] sb_waddr_o,
    output logic [1:0]                   sb_wdata_o,
    // architectural register file commit port
    output logic                         arf_we_o,
    output logic [AREG_ID_BITS-1:0]      arf_waddr_o,
    output logic [XLEN-1:0]              arf_wdata_o,
    // retirement notification
    output logic                         commit_valid_o,
    output logic [ID_BITS-1:0]           commit_id_o,
    output logic                         empty_o
);

    localparam logic [ID_BITS:0] FULL_COUNT = (ID_BITS+1)'(ROBSIZE);

    rob_id_t          head;
    rob_id_t          tail;
    logic [ID_BITS:0] count_reg;
    logic [ID_BITS:0] count_next;

    logic [ROBSIZE-1:0] entry_valid;
    logic [ROBSIZE-1:0] entry_done;

    // Payload storage; only the valid/done flags need a reset.
    areg_t  rd_mem       [ROBSIZE];
    logic   rd_valid_mem [ROBSIZE];
    preg_t  prd_mem      [ROBSIZE];
    xdata_t data_mem     [ROBSIZE];

    wb_t        wb;
    rob_entry_t alloc_entry;

    logic alloc_ready;
    logic alloc_fire;
    logic wb_fire;
    logic wb_ok;
    logic commit_fire;

    logic   prf_we_reg;
    preg_t  prf_waddr_reg;
    xdata_t prf_wdata_reg;

    assign wb.id   = wb_id_i;
    assign wb.data = wb_data_i;

    // Fresh slot image written at the tail on allocation.
    always_comb begin
        alloc_entry          = '0;
        alloc_entry.valid    = 1'b1;
        alloc_entry.done     = 1'b0;
        alloc_entry.rd       = alloc_rd_i;
        alloc_entry.rd_valid = alloc_rd_valid_i;
        alloc_entry.prd      = alloc_prd_i;
        alloc_entry.data     = '0;
    end

    // Fullness is judged on the registered count, so a same-cycle commit
    // never frees a slot for allocation until the following cycle.
    assign alloc_ready = (count_reg != FULL_COUNT) && !flush_i;
    assign alloc_fire  = alloc_valid_i && alloc_ready;

    // Results aimed at dead or already-completed slots are dropped.
    assign wb_fire = wb_valid_i && !flush_i;
    assign wb_ok   = wb_fire && entry_valid[wb.id] && !entry_done[wb.id];

    // done is registered, so a result only becomes retireable a cycle later.
    assign commit_fire = !flush_i && (count_reg != '0) &&
                         entry_valid[head] && entry_done[head];

    rob_ptr #(.W(ID_BITS)) u_head (
        .clk  (clk),
        .rstn (rstn),
        .clr  (flush_i),
        .inc  (commit_fire),
        .ptr  (head)
    );

    rob_ptr #(.W(ID_BITS)) u_tail (
        .clk  (clk),
        .rstn (rstn),
        .clr  (flush_i),
        .inc  (alloc_fire),
        .ptr  (tail)
    );

    // Occupancy: a simultaneous allocate and retire leaves it unchanged.
    always_comb begin
        count_next = count_reg
                   + {{ID_BITS{1'b0}}, alloc_fire}
                   - {{ID_BITS{1'b0}}, commit_fire};
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_reg <= '0;
        end else if (flush_i) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ROBSIZE; gi++) begin : g_entry
            logic valid_reg;
            logic done_reg;

            // Per-slot lifecycle: allocate -> result done -> retire.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    valid_reg <= 1'b0;
                    done_reg  <= 1'b0;
                end else if (flush_i) begin
                    valid_reg <= 1'b0;
                    done_reg  <= 1'b0;
                end else if (alloc_fire && (tail == rob_id_t'(gi))) begin
                    valid_reg <= alloc_entry.valid;
                    done_reg  <= alloc_entry.done;
                end else if (commit_fire && (head == rob_id_t'(gi))) begin
                    valid_reg <= 1'b0;
                    done_reg  <= 1'b0;
                end else if (wb_ok && (wb.id == rob_id_t'(gi))) begin
                    done_reg  <= 1'b1;
                end
            end

            assign entry_valid[gi] = valid_reg;
            assign entry_done[gi]  = done_reg;
        end
    endgenerate

    // Payload writes: rename fields at allocation, result data at writeback.
    // The two never target the same slot because the tail slot is not live.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            rd_mem[tail]       <= alloc_entry.rd;
            rd_valid_mem[tail] <= alloc_entry.rd_valid;
            prd_mem[tail]      <= alloc_entry.prd;
            data_mem[tail]     <= alloc_entry.data;
        end
        if (wb_ok) begin
            data_mem[wb.id] <= wb.data;
        end
    end

    // Registered PRF/scoreboard update; flush does not cancel it, reset does.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prf_we_reg    <= 1'b0;
            prf_waddr_reg <= '0;
            prf_wdata_reg <= '0;
        end else begin
            prf_we_reg    <= wb_ok;
            prf_waddr_reg <= wb_ok ? prd_mem[wb.id] : '0;
            prf_wdata_reg <= wb_ok ? wb.data : '0;
        end
    end

    assign prf_we_o    = prf_we_reg;
    assign prf_waddr_o = prf_waddr_reg;
    assign prf_wdata_o = prf_wdata_reg;

    // Scoreboard: set port follows the PRF write, clear port follows rename.
    always_comb begin
        sb_we_o       = '0;
        sb_waddr_o    = '0;
        sb_wdata_o    = '0;
        sb_we_o[0]    = prf_we_reg;
        sb_waddr_o[0] = prf_waddr_reg;
        sb_wdata_o[0] = prf_we_reg;
        sb_we_o[1]    = alloc_fire && alloc_rd_valid_i;
        sb_waddr_o[1] = alloc_fire ? alloc_prd_i : '0;
        sb_wdata_o[1] = 1'b0;
    end

    // Retirement from the head; data outputs held at zero when idle.
    always_comb begin
        commit_valid_o = commit_fire;
        commit_id_o    = '0;
        arf_we_o       = 1'b0;
        arf_waddr_o    = '0;
        arf_wdata_o    = '0;
        if (commit_fire) begin
            commit_id_o = head;
            arf_we_o    = arf_writes(rd_valid_mem[head], rd_mem[head]);
            arf_waddr_o = rd_mem[head];
            arf_wdata_o = data_mem[head];
        end
    end

    assign alloc_ready_o = alloc_ready;
    assign alloc_id_o    = tail;
    assign wb_ready_o    = !flush_i;
    assign empty_o       = (count_reg == '0);

`ifndef SYNTHESIS
    // Flag results that target a slot which cannot accept them.
    always @(posedge clk) begin
        if (rstn && wb_fire && !wb_ok) begin
            $warning("rob_commit: writeback to id %0d dropped (slot not live or already done)", wb.id);
        end
    end
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: table-driven allocation vectors, hand-written
// multi-cycle sequences, and a queue-based monitor for PRF and commit traffic.
module tb_rob_commit;
    import rob_commit_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic flush = 1'b0;
    logic alloc_valid = 1'b0;
    logic alloc_rd_valid = 1'b0;
    logic [AREG_ID_BITS-1:0] alloc_rd = '0;
    logic [PREG_ID_BITS-1:0] alloc_prd = '0;
    logic wb_valid = 1'b0;
    logic [ID_BITS-1:0] wb_id = '0;
    logic [XLEN-1:0] wb_data = '0;

    logic alloc_ready_o, wb_ready_o, prf_we_o, arf_we_o, commit_valid_o, empty_o;
    logic [ID_BITS-1:0] alloc_id_o, commit_id_o;
    logic [PREG_ID_BITS-1:0] prf_waddr_o;
    logic [XLEN-1:0] prf_wdata_o, arf_wdata_o;
    logic [1:0] sb_we_o, sb_wdata_o;
    logic [1:0][PREG_ID_BITS-1:0] sb_waddr_o;
    logic [AREG_ID_BITS-1:0] arf_waddr_o;

    rob_commit dut (
        .clk(clk), .rstn(rstn), .flush_i(flush),
        .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready_o),
        .alloc_rd_i(alloc_rd), .alloc_rd_valid_i(alloc_rd_valid),
        .alloc_prd_i(alloc_prd), .alloc_id_o(alloc_id_o),
        .wb_valid_i(wb_valid), .wb_ready_o(wb_ready_o),
        .wb_id_i(wb_id), .wb_data_i(wb_data),
        .prf_we_o(prf_we_o), .prf_waddr_o(prf_waddr_o), .prf_wdata_o(prf_wdata_o),
        .sb_we_o(sb_we_o), .sb_waddr_o(sb_waddr_o), .sb_wdata_o(sb_wdata_o),
        .arf_we_o(arf_we_o), .arf_waddr_o(arf_waddr_o), .arf_wdata_o(arf_wdata_o),
        .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o),
        .empty_o(empty_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ID_BITS-1:0]      id;
        logic [AREG_ID_BITS-1:0] rd;
        logic                    rdv;
    } commit_exp_t;

    typedef struct {
        int                      due;
        logic [PREG_ID_BITS-1:0] prd;
        logic [XLEN-1:0]         data;
    } prf_exp_t;

    typedef struct {
        logic [AREG_ID_BITS-1:0] rd;
        logic                    rdv;
        logic [PREG_ID_BITS-1:0] prd;
        logic [XLEN-1:0]         data;
        logic [ID_BITS-1:0]      exp_id;
        logic                    exp_sb;
    } vec_t;

    commit_exp_t commit_q[$];
    prf_exp_t    prf_q[$];

    logic                    m_valid    [ROBSIZE];
    logic                    m_done     [ROBSIZE];
    int                      m_done_cyc [ROBSIZE];
    logic [PREG_ID_BITS-1:0] m_prd      [ROBSIZE];
    logic [XLEN-1:0]         m_data     [ROBSIZE];
    logic [ID_BITS-1:0]      m_tail;

    int cyc = 0;
    int checks = 0;
    int fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < ROBSIZE; i++) begin
            m_valid[i]    = 1'b0;
            m_done[i]     = 1'b0;
            m_done_cyc[i] = 0;
        end
        commit_q.delete();
        m_tail = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_empty"}, empty_o, 1);
        check({tag, "_alloc_ready"}, alloc_ready_o, 1);
        check({tag, "_alloc_id"}, alloc_id_o, 0);
        check({tag, "_commit_valid"}, commit_valid_o, 0);
        check({tag, "_commit_id"}, commit_id_o, 0);
        check({tag, "_prf_we"}, prf_we_o, 0);
        check({tag, "_prf_waddr"}, prf_waddr_o, 0);
        check({tag, "_prf_wdata"}, prf_wdata_o, 0);
        check({tag, "_sb_we"}, sb_we_o, 0);
        check({tag, "_sb_waddr"}, sb_waddr_o, 0);
        check({tag, "_sb_wdata"}, sb_wdata_o, 0);
        check({tag, "_arf_we"}, arf_we_o, 0);
        check({tag, "_arf_waddr"}, arf_waddr_o, 0);
        check({tag, "_arf_wdata"}, arf_wdata_o, 0);
    endtask

    // Monitor: compares PRF/scoreboard writes and retirements with the queues.
    always @(negedge clk) begin
        #1;
        if (rstn) monitor_step();
    end

    task automatic monitor_step();
        logic        exp_c;
        logic        exp_p;
        logic        exp_arf;
        commit_exp_t ce;
        prf_exp_t    pe;
        exp_c = 1'b0;
        if (!flush && commit_q.size() > 0) begin
            ce = commit_q[0];
            exp_c = m_done[ce.id] && (cyc > m_done_cyc[ce.id]);
        end
        check("commit_valid", commit_valid_o, exp_c);
        if (exp_c) begin
            ce = commit_q.pop_front();
            exp_arf = ce.rdv && (ce.rd != 0);
            check("commit_id", commit_id_o, ce.id);
            check("arf_we", arf_we_o, exp_arf);
            if (exp_arf) begin
                check("arf_waddr", arf_waddr_o, ce.rd);
                check("arf_wdata", arf_wdata_o, m_data[ce.id]);
            end
            m_valid[ce.id] = 1'b0;
            m_done[ce.id]  = 1'b0;
            $display("commit id=%0d rd=%0d arf_we=%0b data=%0h", commit_id_o, arf_waddr_o, arf_we_o, arf_wdata_o);
        end else begin
            check("arf_we_idle", arf_we_o, 0);
        end
        exp_p = (prf_q.size() > 0) && (prf_q[0].due <= cyc);
        check("prf_we", prf_we_o, exp_p);
        check("sb_set_we", sb_we_o[0], exp_p);
        if (exp_p) begin
            pe = prf_q.pop_front();
            check("prf_waddr", prf_waddr_o, pe.prd);
            check("prf_wdata", prf_wdata_o, pe.data);
            check("sb_set_waddr", sb_waddr_o[0], pe.prd);
            check("sb_set_wdata", sb_wdata_o[0], 1);
            $display("prf write prd=%0d data=%0h", prf_waddr_o, prf_wdata_o);
        end
    endtask

    // One allocation attempt; acceptance is predicted from the model.
    task automatic alloc(input logic [AREG_ID_BITS-1:0] rd, input logic rdv,
                         input logic [PREG_ID_BITS-1:0] prd,
                         output logic [ID_BITS-1:0] got_id, output logic got_sb,
                         output logic got_ready);
        logic exp_ok;
        commit_exp_t ce;
        alloc_valid = 1'b1;
        alloc_rd = rd;
        alloc_rd_valid = rdv;
        alloc_prd = prd;
        @(negedge clk);
        exp_ok = (commit_q.size() != ROBSIZE) && !flush;
        got_id = alloc_id_o;
        got_sb = sb_we_o[1];
        got_ready = alloc_ready_o;
        check("alloc_ready", alloc_ready_o, exp_ok);
        if (exp_ok) begin
            check("alloc_id", alloc_id_o, m_tail);
            check("sb_clr_we", sb_we_o[1], rdv);
            if (rdv) check("sb_clr_waddr", sb_waddr_o[1], prd);
            check("sb_clr_wdata", sb_wdata_o[1], 0);
            ce.id = m_tail;
            ce.rd = rd;
            ce.rdv = rdv;
            commit_q.push_back(ce);
            m_valid[m_tail] = 1'b1;
            m_done[m_tail]  = 1'b0;
            m_prd[m_tail]   = prd;
            $display("alloc id=%0d rd=%0d rdv=%0b prd=%0d", m_tail, rd, rdv, prd);
            m_tail = m_tail + 1'b1;
        end else begin
            check("sb_clr_we_blocked", sb_we_o[1], 0);
            $display("alloc rejected");
        end
        @(posedge clk);
        #1;
        alloc_valid = 1'b0;
        alloc_rd_valid = 1'b0;
    endtask

    // One writeback; the expected PRF write is queued only for live slots.
    task automatic wb(input logic [ID_BITS-1:0] id, input logic [XLEN-1:0] d);
        prf_exp_t pe;
        wb_valid = 1'b1;
        wb_id = id;
        wb_data = d;
        if (m_valid[id] && !m_done[id]) begin
            pe.due = cyc + 1;
            pe.prd = m_prd[id];
            pe.data = d;
            prf_q.push_back(pe);
            m_done[id] = 1'b1;
            m_done_cyc[id] = cyc;
            m_data[id] = d;
        end
        $display("writeback id=%0d data=%0h", id, d);
        @(negedge clk);
        check("wb_ready", wb_ready_o, 1);
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        logic [ID_BITS-1:0] got_id;
        logic got_sb, got_ready;

        vecs[0] = '{5'd5, 1'b1, 6'd10, 64'h55, 4'd0, 1'b1};
        vecs[1] = '{5'd6, 1'b1, 6'd11, 64'hAA, 4'd1, 1'b1};
        vecs[2] = '{5'd7, 1'b1, 6'd12, 64'h77, 4'd2, 1'b1};
        vecs[3] = '{5'd0, 1'b1, 6'd13, 64'hD0, 4'd3, 1'b1};
        vecs[4] = '{5'd9, 1'b0, 6'd14, 64'h99, 4'd4, 1'b0};

        model_clear();
        prf_q.delete();

        // Reset state
        #2;
        check_reset_outputs("reset");
        #10 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Allocation vectors
        for (int i = 0; i < 5; i++) begin
            alloc(vecs[i].rd, vecs[i].rdv, vecs[i].prd, got_id, got_sb, got_ready);
            check("vec_ready", got_ready, 1);
            check("vec_id", got_id, vecs[i].exp_id);
            check("vec_sb_clr", got_sb, vecs[i].exp_sb);
        end
        @(negedge clk);
        check("not_empty", empty_o, 0);
        check("sb_clr_idle", sb_we_o[1], 0);
        @(posedge clk);
        #1;

        // Out-of-order results, in-order retirement
        wb(4'd1, vecs[1].data);
        @(negedge clk);
        check("ooo_prf_we", prf_we_o, 1);
        check("ooo_prf_waddr", prf_waddr_o, 11);
        check("ooo_no_commit", commit_valid_o, 0);
        @(posedge clk);
        #1;
        wb(4'd0, vecs[0].data);
        @(negedge clk);
        check("c0_valid", commit_valid_o, 1);
        check("c0_id", commit_id_o, 0);
        check("c0_waddr", arf_waddr_o, 5);
        check("c0_wdata", arf_wdata_o, 64'h55);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("c1_valid", commit_valid_o, 1);
        check("c1_id", commit_id_o, 1);
        check("c1_waddr", arf_waddr_o, 6);
        check("c1_wdata", arf_wdata_o, 64'hAA);
        @(posedge clk);
        #1;
        wb(4'd2, vecs[2].data);
        wb(4'd3, vecs[3].data);
        // rd = x0: PRF written, retirement reported, no ARF write
        @(negedge clk);
        check("x0_commit", commit_valid_o, 1);
        check("x0_id", commit_id_o, 3);
        check("x0_arf_we", arf_we_o, 0);
        check("x0_prf_we", prf_we_o, 1);
        check("x0_prf_waddr", prf_waddr_o, 13);
        @(posedge clk);
        #1;
        wb(4'd4, vecs[4].data);
        idle(3);
        check("drained_empty", empty_o, 1);

        // Advance pointers to the wrap point
        for (int k = 5; k < 16; k++) alloc(5'(k), 1'b1, 6'(20 + k), got_id, got_sb, got_ready);
        for (int k = 5; k < 16; k++) wb(4'(k), 64'(k * 257));
        idle(3);
        check("wrap_empty", empty_o, 1);
        check("wrap_alloc_id", alloc_id_o, 0);

        // Fill to capacity
        for (int k = 0; k < 16; k++) alloc(5'(k + 1), 1'b1, 6'(32 + k), got_id, got_sb, got_ready);
        alloc(5'd3, 1'b1, 6'd63, got_id, got_sb, got_ready);
        check("full_reject", got_ready, 0);
        wb(4'd0, 64'hC0);
        alloc(5'd3, 1'b1, 6'd62, got_id, got_sb, got_ready);
        check("full_commit_reject", got_ready, 0);
        alloc(5'd3, 1'b1, 6'd62, got_id, got_sb, got_ready);
        check("after_full_accept", got_ready, 1);
        check("after_full_id", got_id, 0);
        for (int k = 1; k <= 16; k++) wb(4'(k), 64'(k + 64'h1000));
        idle(3);
        check("full_drained", empty_o, 1);

        // Flush with live entries and one pending result
        for (int k = 0; k < 4; k++) alloc(5'(10 + k), 1'b1, 6'(40 + k), got_id, got_sb, got_ready);
        wb(4'd1, 64'hF1);
        flush = 1'b1;
        alloc_valid = 1'b1;
        alloc_rd_valid = 1'b1;
        @(negedge clk);
        check("flush_alloc_ready", alloc_ready_o, 0);
        check("flush_wb_ready", wb_ready_o, 0);
        check("flush_commit", commit_valid_o, 0);
        check("flush_arf_we", arf_we_o, 0);
        check("flush_prf_we", prf_we_o, 1);
        check("flush_prf_waddr", prf_waddr_o, 40);
        check("flush_prf_wdata", prf_wdata_o, 64'hF1);
        model_clear();
        @(posedge clk);
        #1;
        flush = 1'b0;
        alloc_valid = 1'b0;
        alloc_rd_valid = 1'b0;
        @(negedge clk);
        check("post_flush_empty", empty_o, 1);
        check("post_flush_alloc_id", alloc_id_o, 0);
        check("post_flush_commit", commit_valid_o, 0);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-stream
        alloc(5'd3, 1'b1, 6'd50, got_id, got_sb, got_ready);
        alloc(5'd4, 1'b1, 6'd51, got_id, got_sb, got_ready);
        wb(4'd0, 64'h600D);
        #2 rstn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_clear();
        prf_q.delete();
        @(negedge clk);
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;
        wb(4'd1, 64'hDEAD);
        @(negedge clk);
        check("stale_wb_prf_we", prf_we_o, 0);
        check("stale_wb_empty", empty_o, 1);
        @(posedge clk);
        #1;
        alloc(5'd8, 1'b1, 6'd60, got_id, got_sb, got_ready);
        check("post_rst_id", got_id, 0);
        wb(4'd0, 64'h1234);
        idle(3);
        check("final_empty", empty_o, 1);
        check("commit_q_drained", commit_q.size(), 0);
        check("prf_q_drained", prf_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
